// File: rtl/display_source_select.sv
// Display source selector feeding the 4-digit hex display stage.
// Owns the CPU output port, debounces the mode button, registers the shown value.
module display_source_select #(
    parameter int          DATA_W          = 14,
    parameter logic [3:0]  PORT_ADDR       = 4'hF,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_wr_en,
    input  logic [3:0]        io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] acc,
    input  logic              btn_mode_n,
    input  logic              freeze,
    output logic [DATA_W-1:0] disp_value,
    output logic [1:0]        disp_mode,
    output logic              wr_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_PORT = 2'd0,
        MODE_PC   = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_BAD  = 2'd3
    } mode_t;

    mode_t             state;
    mode_t             state_next;
    logic              sync_a;
    logic              btn_s;
    logic              btn_lvl;
    logic [CNT_W-1:0]  deb_cnt;
    logic              accept;
    logic              press;
    logic [DATA_W-1:0] port_reg;
    logic              port_hit;
    logic [DATA_W-1:0] src;

    // Two-flop synchronizer for the asynchronous pushbutton (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            btn_s  <= 1'b1;
        end else begin
            sync_a <= btn_mode_n;
            btn_s  <= sync_a;
        end
    end

    // A new level is accepted only after it stays stable long enough
    assign accept = (btn_s != btn_lvl) && (deb_cnt == CNT_MAX);

    // Accepted falling edge of the debounced level is a press
    assign press = accept && !btn_s;

    // Debounce counter restarts whenever the input agrees with the level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_lvl <= 1'b1;
            deb_cnt <= '0;
        end else if (btn_s == btn_lvl) begin
            deb_cnt <= '0;
        end else if (accept) begin
            btn_lvl <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_PORT;
        end else begin
            state <= state_next;
        end
    end

    // Mode sequencing: PORT -> PC -> ACC -> PORT; illegal code recovers
    always_comb begin
        state_next = state;
        unique case (state)
            MODE_PORT: if (press) state_next = MODE_PC;
            MODE_PC:   if (press) state_next = MODE_ACC;
            MODE_ACC:  if (press) state_next = MODE_PORT;
            MODE_BAD:  state_next = MODE_PORT;
        endcase
    end

    assign disp_mode = state;

    assign port_hit = io_wr_en && (io_addr == PORT_ADDR);

    // Output port capture with a one-cycle acknowledge per accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_reg <= '0;
            wr_ack   <= 1'b0;
        end else begin
            wr_ack <= port_hit;
            if (port_hit) begin
                port_reg <= io_wdata;
            end
        end
    end

    // Source selected by the current mode
    always_comb begin
        src = port_reg;
        unique case (state)
            MODE_PORT: src = port_reg;
            MODE_PC:   src = pc;
            MODE_ACC:  src = acc;
            MODE_BAD:  src = port_reg;
        endcase
    end

    // Display register, held while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_value <= '0;
        end else if (!freeze) begin
            disp_value <= src;
        end
    end

endmodule

// File: tb/tb_display_source_select.sv
// Self-checking bench for display_source_select.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_display_source_select;

    localparam int W = 14;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         io_wr_en;
    logic [3:0]   io_addr;
    logic [W-1:0] io_wdata;
    logic [W-1:0] pc;
    logic [W-1:0] acc;
    logic         btn_mode_n;
    logic         freeze;
    logic [W-1:0] disp_value;
    logic [1:0]   disp_mode;
    logic         wr_ack;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    display_source_select #(
        .DATA_W(W),
        .PORT_ADDR(4'hF),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_wr_en(io_wr_en),
        .io_addr(io_addr),
        .io_wdata(io_wdata),
        .pc(pc),
        .acc(acc),
        .btn_mode_n(btn_mode_n),
        .freeze(freeze),
        .disp_value(disp_value),
        .disp_mode(disp_mode),
        .wr_ack(wr_ack)
    );

    // Behavioural reference: raw button delayed two samples, accepted after
    // D consecutive disagreeing samples; modes cycle modulo 3.
    int           m_mode;
    logic [W-1:0] m_port;
    logic [W-1:0] m_disp;
    bit           m_ack;
    bit           m_lvl;
    bit           m_s1;
    bit           m_s2;
    int           m_run;

    always @(posedge clk or negedge rst_n) begin : model
        logic [W-1:0] s;
        bit pr;
        if (!rst_n) begin
            m_mode = 0;
            m_port = '0;
            m_disp = '0;
            m_ack  = 0;
            m_lvl  = 1;
            m_s1   = 1;
            m_s2   = 1;
            m_run  = 0;
        end else begin
            if (m_mode == 1) s = pc;
            else if (m_mode == 2) s = acc;
            else s = m_port;
            if (!freeze) m_disp = s;
            pr = 0;
            if (m_s2 == m_lvl) begin
                m_run = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run >= D) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    pr = !m_s2;
                end
            end
            if (pr) m_mode = (m_mode + 1) % 3;
            m_ack = io_wr_en && (io_addr == 4'hF);
            if (m_ack) m_port = io_wdata;
            m_s2 = m_s1;
            m_s1 = btn_mode_n;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (disp_value !== '0) begin
            bad++;
            $display("FAIL reset_disp got=%h exp=0", disp_value);
        end
        total++;
        if (disp_mode !== 2'd0) begin
            bad++;
            $display("FAIL reset_mode got=%0d exp=0", disp_mode);
        end
        total++;
        if (wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack got=%b exp=0", wr_ack);
        end
    endtask

    task automatic test_port_write();
        io_wr_en = 1;
        io_addr  = 4'hF;
        io_wdata = 14'h2A5B;
        @(negedge clk);
        io_wr_en = 0;
        total++;
        if (wr_ack !== 1'b1) begin
            bad++;
            $display("FAIL wr_ack_pulse got=%b exp=1", wr_ack);
        end
        @(negedge clk);
        total++;
        if (disp_value !== 14'h2A5B) begin
            bad++;
            $display("FAIL port_latency got=%h exp=2a5b", disp_value);
        end
        total++;
        if (wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack_single got=%b exp=0", wr_ack);
        end
        total++;
        if (disp_mode !== 2'd0) begin
            bad++;
            $display("FAIL port_mode got=%0d exp=0", disp_mode);
        end
    endtask

    task automatic test_bad_addr();
        io_wr_en = 1;
        io_addr  = 4'h3;
        io_wdata = 14'h1111;
        @(negedge clk);
        io_wr_en = 0;
        total++;
        if (wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL bad_addr_ack got=%b exp=0", wr_ack);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (disp_value !== 14'h2A5B) begin
            bad++;
            $display("FAIL bad_addr_disp got=%h exp=2a5b", disp_value);
        end
    endtask

    task automatic press_once(input string tag);
        btn_mode_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (disp_mode !== 2'(m_mode)) begin
                bad++;
                $display("FAIL %s_mode_low got=%0d exp=%0d", tag, disp_mode, m_mode);
            end
        end
        btn_mode_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
        end
        total++;
        if (disp_mode !== 2'(m_mode)) begin
            bad++;
            $display("FAIL %s_mode_rel got=%0d exp=%0d", tag, disp_mode, m_mode);
        end
    endtask

    task automatic test_mode_press();
        pc = 14'h0123;
        press_once("press1");
        total++;
        if (disp_mode !== 2'd1) begin
            bad++;
            $display("FAIL press_to_pc got=%0d exp=1", disp_mode);
        end
        total++;
        if (disp_value !== 14'h0123) begin
            bad++;
            $display("FAIL disp_pc got=%h exp=0123", disp_value);
        end
        press_once("press2");
        total++;
        if (disp_mode !== 2'd2) begin
            bad++;
            $display("FAIL press_to_acc got=%0d exp=2", disp_mode);
        end
        press_once("press3");
        total++;
        if (disp_mode !== 2'd0) begin
            bad++;
            $display("FAIL press_wrap got=%0d exp=0", disp_mode);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            btn_mode_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        btn_mode_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
        end
        total++;
        if (disp_mode !== 2'd0) begin
            bad++;
            $display("FAIL bounce_mode got=%0d exp=0", disp_mode);
        end
    endtask

    task automatic test_freeze();
        pc = 14'h0123;
        press_once("fz_pre");
        freeze = 1;
        pc = 14'h0456;
        press_once("fz_press");
        total++;
        if (disp_value !== 14'h0123) begin
            bad++;
            $display("FAIL freeze_hold got=%h exp=0123", disp_value);
        end
        total++;
        if (disp_mode !== 2'd2) begin
            bad++;
            $display("FAIL freeze_mode got=%0d exp=2", disp_mode);
        end
        acc = 14'h3FFF;
        freeze = 0;
        @(negedge clk);
        total++;
        if (disp_value !== 14'h3FFF) begin
            bad++;
            $display("FAIL freeze_release got=%h exp=3fff", disp_value);
        end
    endtask

    task automatic test_back_to_back();
        io_wr_en = 1;
        io_addr  = 4'hF;
        io_wdata = 14'h1ABC;
        @(negedge clk);
        io_wdata = 14'h0DEF;
        total++;
        if (wr_ack !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ack1 got=%b exp=1", wr_ack);
        end
        @(negedge clk);
        io_wr_en = 0;
        total++;
        if (wr_ack !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ack2 got=%b exp=1", wr_ack);
        end
        total++;
        if (dut.port_reg !== 14'h0DEF) begin
            bad++;
            $display("FAIL b2b_port got=%h exp=0def", dut.port_reg);
        end
        @(negedge clk);
        total++;
        if (wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ack_end got=%b exp=0", wr_ack);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            total++;
            if (disp_value !== m_disp || disp_mode !== 2'(m_mode) ||
                wr_ack !== m_ack) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%0d/%b exp=%h/%0d/%b", i,
                         disp_value, disp_mode, wr_ack, m_disp, m_mode, m_ack);
            end
            io_wr_en = ($urandom_range(0, 3) == 0);
            io_addr  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            io_wdata = W'($urandom);
            pc       = W'($urandom);
            acc      = W'($urandom);
            if ($urandom_range(0, 7) == 0) freeze = ~freeze;
            if (hold == 0) begin
                btn_mode_n = ~btn_mode_n;
                hold = $urandom_range(1, 9);
            end else begin
                hold--;
            end
        end
        freeze = 0;
        io_wr_en = 0;
        btn_mode_n = 1;
    endtask

    task automatic test_reset_mid();
        io_wr_en = 1;
        io_addr  = 4'hF;
        io_wdata = 14'h2A5B;
        @(negedge clk);
        io_wr_en = 0;
        btn_mode_n = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        io_wr_en = 1;
        io_wdata = 14'h1555;
        #2 rst_n = 0;
        #1;
        total++;
        if (disp_value !== '0 || dut.port_reg !== '0) begin
            bad++;
            $display("FAIL mid_rst_data got=%h/%h exp=0/0", disp_value, dut.port_reg);
        end
        total++;
        if (disp_mode !== 2'd0 || wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_ctrl got=%0d/%b exp=0/0", disp_mode, wr_ack);
        end
        io_wr_en = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (disp_mode !== 2'd0 || wr_ack !== 1'b0) begin
                bad++;
                $display("FAIL post_rst_%0d got=%0d/%b exp=0/0", i, disp_mode, wr_ack);
            end
        end
        btn_mode_n = 1;
    endtask

    initial begin
        rst_n      = 0;
        io_wr_en   = 0;
        io_addr    = 4'h0;
        io_wdata   = '0;
        pc         = '0;
        acc        = '0;
        btn_mode_n = 1;
        freeze     = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_port_write();
        test_bad_addr();
        test_mode_press();
        test_bounce();
        test_freeze();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_source_select.md
Name: display_source_select

Overview:
Upstream feeder for the 4-digit hex display stage. It owns the CPU's output-port register, samples the program counter and accumulator, and registers one 14-bit value for display. A debounced pushbutton cycles the display source (PORT -> PC -> ACC), and a freeze switch holds the shown value. Its disp_value output drives the 14-bit binary input of the hex display stage directly.

Parameters:
DATA_W, 14, width of all displayed values; it matches the 14-bit display input.
PORT_ADDR, 4'hF, I/O address decoded as the display output port.
DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles required to accept a button level (1 ms at 50 MHz).
CNT_W, 16, width of the debounce counter; it must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
io_wr_en  input  1  CPU I/O write strobe, valid for one cycle.
io_addr  input  4  CPU I/O address.
io_wdata  input  DATA_W  CPU I/O write data.
pc  input  DATA_W  CPU program counter (synchronous to clk).
acc  input  DATA_W  CPU accumulator (synchronous to clk).
btn_mode_n  input  1  raw pushbutton, active-low, asynchronous to clk.
freeze  input  1  1 holds disp_value; synchronous to clk.
disp_value  output  DATA_W  registered value to the hex display stage.
disp_mode  output  2  current source: 0=PORT, 1=PC, 2=ACC.
wr_ack  output  1  one-cycle pulse confirming that a port write was captured.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - port_reg=0, disp_value=0, disp_mode=0 (PORT), wr_ack=0.
  - Both synchronizer flops=1; debounced level=1 (released); debounce counter=0.
- Button synchronizer: two flops on btn_mode_n, giving btn_s. The raw input is never used elsewhere.
- Debounce:
  - If btn_s equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, on that edge the debounced level takes btn_s and the counter clears.
  - Any return of btn_s to the debounced level before then restarts the count, so bounce is rejected.
- Press detection: a debounced 1->0 transition produces press, a one-cycle internal pulse. The 0->1 release produces nothing.
- Mode FSM, advanced on press:
  - PORT(0) -> PC(1) -> ACC(2) -> PORT(0), wrapping.
  - Encoding 3 is illegal and returns to PORT on the next edge.
  - disp_mode is the state register itself.
- Port write:
  - When io_wr_en=1 and io_addr==PORT_ADDR, port_reg takes io_wdata on that edge and wr_ack is 1 for exactly the following cycle.
  - Non-matching addresses are ignored and give no wr_ack.
  - Port writes are captured regardless of mode and freeze.
  - Back-to-back writes in consecutive cycles are each captured; wr_ack stays high for both cycles.
- Display register:
  - freeze=1: disp_value holds.
  - freeze=0: disp_value takes the source selected by the current mode (port_reg, pc or acc) on each edge.
- Latency, with freeze=0:
  - Port write appears on disp_value 2 edges after the write cycle (port_reg, then disp_value).
  - pc/acc changes appear after 1 edge.
  - A mode change is reflected on disp_value 1 edge after disp_mode changes.
- Freeze interaction: presses during freeze still advance the mode. On freeze release, disp_value takes the new mode's source on the next edge.
- Simultaneous events: a port write and a press in the same cycle both take effect.
- Reset mid-operation: a reset during an active debounce count or pending write discards them. wr_ack is 0 immediately and stays 0 until a new write.
- Arithmetic: no arithmetic on data, all transfers are DATA_W-wide. The counter saturates conceptually because it clears at DEBOUNCE_CYCLES-1 and never wraps.

Test Plan:
(Use DEBOUNCE_CYCLES=4 in simulation.)
1. Reset, then write io_addr=F, io_wdata=14'h2A5B (freeze=0, mode PORT) -> wr_ack=1 one cycle later; disp_value=14'h2A5B 2 edges after the write; disp_mode=0.
2. Write with io_addr=3, data 14'h1111 -> no wr_ack; port_reg and disp_value unchanged.
3. Hold btn_mode_n=0 for 10 cycles -> exactly one advance, disp_mode 0->1; disp_value follows pc (pc=14'h0123 -> 14'h0123 one edge later). Two more clean presses -> disp_mode 2, then 0.
4. Bounce: btn_mode_n toggles every 2 cycles for 20 cycles, then returns high -> disp_mode unchanged.
5. freeze=1 with disp_value=14'h0123, change pc to 14'h0456 and press once -> disp_value stays 14'h0123 and disp_mode=2. Release freeze with acc=14'h3FFF -> disp_value=14'h3FFF next edge.
6. Assert rst_n=0 mid-debounce with port_reg=14'h2A5B -> disp_value, port_reg, disp_mode and wr_ack all 0 asynchronously. After release, 3 stable low cycles produce no press.
